mux_8by2: RTL and testbench
===========================

# mux_8by2

Eight-input, one-output selector built as a three-level tree of seven identical 2:1 multiplexers. The combinational output follows the select and data inputs with no clock latency. A registered copy of the output, with asynchronous active-low clear, is provided for downstream synchronous logic. The block is a leaf primitive used wherever an 8-way data steer is needed.

## Interface
- DATA_W, default 1: width of each of the eight data lanes.
- clk  input  1  rising-edge clock for the registered output only.
- rst_n  input  1  asynchronous, active-low reset; clears Y_q.
- A  input  8*DATA_W  packed data lanes; lane i occupies A[i*DATA_W +: DATA_W], with lane 0 in the LSBs.
- S  input  3  lane select, unsigned, 0..7.
- Y  output  DATA_W  combinational selected lane, Y = lane S of A.
- Y_q  output  DATA_W  Y registered on the rising edge of clk.
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- Level 1 uses four mux2 instances, all selected by S[0]:
  - n0 = S[0] ? lane1 : lane0
  - n1 = S[0] ? lane3 : lane2
  - n2 = S[0] ? lane5 : lane4
  - n3 = S[0] ? lane7 : lane6
- Level 2 uses two mux2 instances, selected by S[1]:
  - m0 = S[1] ? n1 : n0
  - m1 = S[1] ? n3 : n2
- Level 3 uses one mux2 instance, selected by S[2]: Y = S[2] ? m1 : m0.
- Net function: Y equals lane S, for all 8 select values and every data pattern. Unselected lanes have no effect on Y.
- mux2 semantics are out = sel ? in1 : in0.
- X or Z on S propagates X to Y. No X-masking logic is added.
- Y_q:
  - Loads Y at every rising edge of clk while rst_n = 1.
  - Has no enable.
- No state other than Y_q. No FSM.

## Timing
- Y has zero-cycle latency and is purely combinational from A and S, with a critical path of 3 mux2 levels.
- A change on A or S must be visible on Y within the same simulation delta region, with no #delays in RTL.
- Y_q has 1-cycle latency: Y_q after edge k equals Y sampled just before edge k.
- Reset:
  - rst_n falling clears Y_q to 0 immediately, without waiting for clk.
  - Y_q holds 0 while rst_n = 0.
  - The first load happens at the first rising edge of clk after rst_n rises.
- Y is unaffected by rst_n and clk at all times, including during reset.
- Reset mid-operation clears only Y_q. Y keeps tracking A and S.

## Structure
- Sub-module mux2, parameterized by DATA_W, with ports in0, in1, sel, out. It is instantiated 7 times via explicit instances or a generate loop over levels.
- Shared package mux_pkg:
  - NUM_LANES = 8
  - SEL_W = 3
  - lane-extract helper function
- The top level contains the tree wiring and the single Y_q register process only.

## Test plan
- One-hot walk, DATA_W=1:
  - A = 8'b0000_0001 with S = 0, then A = 8'b0000_0010 with S = 1, and so on up to A = 8'b1000_0000 with S = 7, changing every 5 ns.
  - Required: Y = 1 at every step.
- Mismatched select: A = 8'b0000_0001 with S = 1..7 -> Y = 0 for each. Then A = 8'b1111_1110 with S = 0 -> Y = 0.
- Exhaustive: all 256 values of A crossed with all 8 values of S -> Y == A[S] every time.
- Registered path:
  - Apply A = 8'hA5, S = 2 before a rising edge -> Y_q = 1 after that edge.
  - Change S to 1 -> Y = 0 immediately, and Y_q = 0 only after the next edge.
- Async reset:
  - Assert rst_n = 0 between clock edges while Y_q = 1 -> Y_q = 0 at once.
  - Y still tracks A[S] during reset.
  - Release reset -> Y_q reloads at the next rising edge.
- DATA_W = 4: lanes 0..7 = 4'h0..4'h7, sweep S -> Y = S.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and lane-indexing helper for the 8:1 mux tree.
package mux_pkg;

    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned SEL_W     = 3;

    // Bit offset of lane `lane` inside a packed bus of `lane_w`-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/mux2.sv
// Parameterized 2:1 multiplexer leaf cell; X on sel propagates naturally.
module mux2 #(
    parameter int unsigned DATA_W = 1
) (
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic              sel,
    output logic [DATA_W-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux_8by2.sv
// 8:1 selector as a three-level tree of mux2 cells, plus a registered copy of the output.
module mux_8by2
    import mux_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_LANES*DATA_W-1:0]   A,
    input  logic [SEL_W-1:0]              S,
    output logic [DATA_W-1:0]             Y,
    output logic [DATA_W-1:0]             Y_q
);

    logic [DATA_W-1:0] lane [NUM_LANES];
    logic [DATA_W-1:0] n    [4];
    logic [DATA_W-1:0] m    [2];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane[i] = A[lane_lsb(i, DATA_W) +: DATA_W];
    end

    // Level 1: adjacent lane pairs, steered by S[0].
    for (genvar i = 0; i < 4; i++) begin : g_lvl1
        mux2 #(.DATA_W(DATA_W)) u_mux (
            .in0 (lane[2*i]),
            .in1 (lane[2*i+1]),
            .sel (S[0]),
            .out (n[i])
        );
    end

    // Level 2: pairs of level-1 results, steered by S[1].
    for (genvar i = 0; i < 2; i++) begin : g_lvl2
        mux2 #(.DATA_W(DATA_W)) u_mux (
            .in0 (n[2*i]),
            .in1 (n[2*i+1]),
            .sel (S[1]),
            .out (m[i])
        );
    end

    mux2 #(.DATA_W(DATA_W)) u_lvl3 (
        .in0 (m[0]),
        .in1 (m[1]),
        .sel (S[2]),
        .out (Y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_q <= '0;
        end else begin
            Y_q <= Y;
        end
    end

endmodule

// File: tb/tb_mux_8by2.sv
// Directed self-checking bench for mux_8by2 at DATA_W=1 and DATA_W=4.
module tb_mux_8by2;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a1;
    logic [2:0]  s1;
    logic        y1;
    logic        yq1;
    logic [31:0] a4;
    logic [2:0]  s4;
    logic [3:0]  y4;
    logic [3:0]  yq4;

    int checks;
    int errors;

    mux_8by2 #(.DATA_W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a1),
        .S     (s1),
        .Y     (y1),
        .Y_q   (yq1)
    );

    mux_8by2 #(.DATA_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a4),
        .S     (s4),
        .Y     (y4),
        .Y_q   (yq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        a1 = 8'b0000_1000;
        s1 = 3'd3;
        a4 = 32'h7654_3210;
        s4 = 3'd5;
        #1;
        checks++;
        if (yq1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_yq1: got %b expected 0", yq1);
        end
        checks++;
        if (yq4 !== 4'h0) begin
            errors++;
            $display("FAIL reset_yq4: got %h expected 0", yq4);
        end
        @(posedge clk);
        #1;
        checks++;
        if (yq1 !== 1'b0 || yq4 !== 4'h0) begin
            errors++;
            $display("FAIL reset_hold: got yq1=%b yq4=%h expected 0/0", yq1, yq4);
        end
        checks++;
        if (y1 !== 1'b1 || y4 !== 4'h5) begin
            errors++;
            $display("FAIL reset_y_tracks: got y1=%b y4=%h expected 1/5", y1, y4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_onehot();
        logic [7:0] pat;
        for (int i = 0; i < 8; i++) begin
            pat = 8'd1 << i;
            a1 = pat;
            s1 = 3'(i);
            #5;
            checks++;
            if (y1 !== 1'b1) begin
                errors++;
                $display("FAIL onehot s=%0d: got %b expected 1", i, y1);
            end
        end
    endtask

    task automatic test_mismatch();
        a1 = 8'b0000_0001;
        for (int i = 1; i < 8; i++) begin
            s1 = 3'(i);
            #1;
            checks++;
            if (y1 !== 1'b0) begin
                errors++;
                $display("FAIL mismatch s=%0d: got %b expected 0", i, y1);
            end
        end
        a1 = 8'b1111_1110;
        s1 = 3'd0;
        #1;
        checks++;
        if (y1 !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_inv s=0: got %b expected 0", y1);
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] av;
        logic       exp;
        for (int a = 0; a < 256; a++) begin
            for (int s = 0; s < 8; s++) begin
                av  = 8'(a);
                exp = av[s];
                a1  = av;
                s1  = 3'(s);
                #1;
                checks++;
                if (y1 !== exp) begin
                    errors++;
                    $display("FAIL exhaustive a=%h s=%0d: got %b expected %b", av, s, y1, exp);
                end
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        a1 = 8'hA5;
        s1 = 3'd2;
        @(posedge clk);
        #1;
        checks++;
        if (yq1 !== 1'b1) begin
            errors++;
            $display("FAIL reg_load: got %b expected 1", yq1);
        end
        s1 = 3'd1;
        #1;
        checks++;
        if (y1 !== 1'b0 || yq1 !== 1'b1) begin
            errors++;
            $display("FAIL reg_latency: got y=%b yq=%b expected 0/1", y1, yq1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (yq1 !== 1'b0) begin
            errors++;
            $display("FAIL reg_update: got %b expected 0", yq1);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a1 = 8'hA5;
        s1 = 3'd2;
        @(posedge clk);
        #1;
        checks++;
        if (yq1 !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: got %b expected 1", yq1);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (yq1 !== 1'b0) begin
            errors++;
            $display("FAIL arst_clear: got %b expected 0", yq1);
        end
        s1 = 3'd0;
        #1;
        checks++;
        if (y1 !== 1'b1) begin
            errors++;
            $display("FAIL arst_y_s0: got %b expected 1", y1);
        end
        s1 = 3'd1;
        #1;
        checks++;
        if (y1 !== 1'b0) begin
            errors++;
            $display("FAIL arst_y_s1: got %b expected 0", y1);
        end
        s1 = 3'd7;
        @(posedge clk);
        #1;
        checks++;
        if (yq1 !== 1'b0) begin
            errors++;
            $display("FAIL arst_hold: got %b expected 0", yq1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (yq1 !== 1'b0) begin
            errors++;
            $display("FAIL arst_release: got %b expected 0", yq1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (yq1 !== 1'b1) begin
            errors++;
            $display("FAIL arst_reload: got %b expected 1", yq1);
        end
    endtask

    task automatic test_width4();
        a4 = 32'h7654_3210;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s4 = 3'(i);
            #1;
            checks++;
            if (y4 !== 4'(i)) begin
                errors++;
                $display("FAIL w4 s=%0d: got %h expected %h", i, y4, 4'(i));
            end
            @(posedge clk);
            #1;
            checks++;
            if (yq4 !== 4'(i)) begin
                errors++;
                $display("FAIL w4_q s=%0d: got %h expected %h", i, yq4, 4'(i));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_onehot();
        test_mismatch();
        test_exhaustive();
        test_registered();
        test_async_reset();
        test_width4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
